trap_ctrl: RTL and testbench

//  Interrupt/trap controller sitting directly upstream of the core's `trap` input.
//  - Latches rising edges on external irq lines into a pending register.
//  - Applies a software-writable enable mask and raises `trap` for the

---
 rtl/trap_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: interrupt/trap controller in front of the core's trap input.
// Latches rising irq edges into pending, masks them with enable, and raises
// trap for the lowest-numbered active line. The core acknowledges by writing
// to TRAP_ADDR. Software re-arms the controller by writing EOI.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | no trap outstanding; any active line raises trap next edge
//  ST_REQ   | trap held high, waiting for the core's TRAP_ADDR write
//  ST_INSVC | handler running; new edges only pend until EOI is written
module trap_ctrl #(
    parameter int          IRQ_COUNT = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter logic [31:0] TRAP_ADDR = 32'h0000_0200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IRQ_COUNT-1:0] irq,
    output logic                 trap,
    input  logic                 strobe,
    input  logic                 mem_rw,
    input  logic [31:0]          d_addr,
    input  logic [31:0]          d_wdata,
    output logic [31:0]          d_rdata,
    output logic                 d_hit
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_INSVC = 2'd2
    } state_t;

    localparam logic [1:0] OFF_ENABLE  = 2'd0;
    localparam logic [1:0] OFF_PENDING = 2'd1;
    localparam logic [1:0] OFF_CAUSE   = 2'd2;
    localparam logic [1:0] OFF_EOI     = 2'd3;

    state_t               state_q;
    state_t               state_d;
    logic                 trap_d;
    logic [4:0]           cause;
    logic [4:0]           cause_d;
    logic [IRQ_COUNT-1:0] irq_q;
    logic [IRQ_COUNT-1:0] pending;
    logic [IRQ_COUNT-1:0] pending_d;
    logic [IRQ_COUNT-1:0] enable;
    logic [IRQ_COUNT-1:0] active;
    logic [4:0]           sel;
    logic                 reg_wr;
    logic                 enable_wr;
    logic                 pending_wr;
    logic                 eoi_wr;
    logic                 ack;
    logic                 ack_clear;
    logic [31:0]          enable_ext;
    logic [31:0]          pending_ext;
    logic [31:0]          cause_word;
    logic                 unused_wdata;

    // Only the low IRQ_COUNT bits of write data reach a register.
    assign unused_wdata = ^d_wdata;

    // The window is 4 words aligned to 4, so the upper 30 address bits decide a hit.
    assign d_hit      = strobe & (d_addr[31:2] == BASE_ADDR[31:2]);
    assign reg_wr     = d_hit & mem_rw;
    assign enable_wr  = reg_wr & (d_addr[1:0] == OFF_ENABLE);
    assign pending_wr = reg_wr & (d_addr[1:0] == OFF_PENDING);
    assign eoi_wr     = reg_wr & (d_addr[1:0] == OFF_EOI);
    // TRAP_ADDR is outside the window, so an ack never decodes as a register access.
    assign ack        = strobe & mem_rw & (d_addr == TRAP_ADDR);
    assign active     = pending & enable;

    // Lowest-numbered active line wins: scan downwards so the last hit is the lowest.
    always_comb begin
        sel = '0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel = 5'(i);
            end
        end
    end

    // Next state, trap and cause; trap is held through ST_REQ regardless of mask changes.
    always_comb begin
        state_d   = state_q;
        trap_d    = trap;
        cause_d   = cause;
        ack_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|active) begin
                    state_d = ST_REQ;
                    trap_d  = 1'b1;
                    cause_d = sel;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d   = ST_INSVC;
                    trap_d    = 1'b0;
                    ack_clear = 1'b1;
                end
            end
            ST_INSVC: begin
                if (eoi_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                trap_d  = 1'b0;
            end
        endcase
    end

    // Pending update: ack clear and W1C first, then new edges so an edge beats a clear.
    always_comb begin
        pending_d = pending;
        if (ack_clear) begin
            for (int i = 0; i < IRQ_COUNT; i++) begin
                if (cause == 5'(i)) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
        if (pending_wr) begin
            pending_d = pending_d & ~d_wdata[IRQ_COUNT-1:0];
        end
        pending_d = pending_d | (irq & ~irq_q);
    end

    // State register and trap output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            trap    <= 1'b0;
            cause   <= '0;
        end else begin
            state_q <= state_d;
            trap    <= trap_d;
            cause   <= cause_d;
        end
    end

    // Edge-detect history, pending and enable registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
            enable  <= '0;
        end else begin
            irq_q   <= irq;
            pending <= pending_d;
            if (enable_wr) begin
                enable <= d_wdata[IRQ_COUNT-1:0];
            end
        end
    end

    // Zero-extend the IRQ_COUNT-wide registers to bus width for readback.
    always_comb begin
        enable_ext                  = '0;
        pending_ext                 = '0;
        enable_ext[IRQ_COUNT-1:0]   = enable;
        pending_ext[IRQ_COUNT-1:0]  = pending;
        cause_word                  = '0;
        cause_word[31]              = (state_q == ST_INSVC);
        cause_word[4:0]             = cause;
    end

    // Combinational read mux; EOI and misses read as zero.
    always_comb begin
        d_rdata = '0;
        if (d_hit) begin
            case (d_addr[1:0])
                OFF_ENABLE:  d_rdata = enable_ext;
                OFF_PENDING: d_rdata = pending_ext;
                OFF_CAUSE:   d_rdata = cause_word;
                default:     d_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scenarios with literal expectations, then random
// irq/bus/reset traffic checked every cycle against a behavioural model.
module tb_trap_ctrl;

    localparam int          N     = 8;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] TADDR = 32'h0000_0200;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq;
    logic         trap;
    logic         strobe;
    logic         mem_rw;
    logic [31:0]  d_addr;
    logic [31:0]  d_wdata;
    logic [31:0]  d_rdata;
    logic         d_hit;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit [7:0] m_pend  = '0;
    bit [7:0] m_en    = '0;
    bit [7:0] m_irq_q = '0;
    bit       m_trap  = 1'b0;
    bit       m_svc   = 1'b0;
    int       m_cause = 0;

    trap_ctrl #(.IRQ_COUNT(N), .BASE_ADDR(BASE), .TRAP_ADDR(TADDR)) dut (
        .clk(clk), .reset(reset), .irq(irq), .trap(trap),
        .strobe(strobe), .mem_rw(mem_rw), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_hit(d_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_hit();
        return strobe && (d_addr >= BASE) && (d_addr <= BASE + 3);
    endfunction

    function automatic logic [31:0] exp_rdata();
        logic [31:0] r;
        r = '0;
        if (exp_hit()) begin
            case (d_addr - BASE)
                32'd0: r = {24'd0, m_en};
                32'd1: r = {24'd0, m_pend};
                32'd2: begin
                    r[31]  = m_svc;
                    r[4:0] = 5'(m_cause);
                end
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Model: one step per clock edge, computed from the rules on pre-edge values.
    always @(posedge clk) begin
        bit [7:0] npend;
        bit       wr_hit;
        bit       is_ack;
        bit       found;
        bit       old_trap;
        bit       old_svc;
        int       off;
        if (reset) begin
            m_pend = '0; m_en = '0; m_irq_q = '0;
            m_trap = 1'b0; m_svc = 1'b0; m_cause = 0;
        end else begin
            old_trap = m_trap;
            old_svc  = m_svc;
            wr_hit   = strobe && mem_rw && exp_hit();
            off      = int'(d_addr - BASE);
            is_ack   = strobe && mem_rw && (d_addr == TADDR);
            npend    = m_pend;
            if (old_trap) begin
                if (is_ack) begin
                    m_trap        = 1'b0;
                    m_svc         = 1'b1;
                    npend[m_cause] = 1'b0;
                end
            end else if (!old_svc) begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (!found && m_pend[i] && m_en[i]) begin
                        found   = 1'b1;
                        m_cause = i;
                        m_trap  = 1'b1;
                    end
                end
            end
            if (wr_hit && off == 1) npend = npend & ~d_wdata[7:0];
            if (wr_hit && off == 3 && old_svc) m_svc = 1'b0;
            if (wr_hit && off == 0) m_en = d_wdata[7:0];
            m_pend  = npend | (irq & ~m_irq_q);
            m_irq_q = irq;
        end
    end

    // Compare process: every negedge, outputs against the model.
    always @(negedge clk) begin
        chk("trap", {31'd0, trap}, {31'd0, m_trap});
        chk("d_hit", {31'd0, d_hit}, {31'd0, exp_hit()});
        chk("d_rdata", d_rdata, exp_rdata());
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bus();
        strobe = 1'b0; mem_rw = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        strobe = 1'b1; mem_rw = 1'b1; d_addr = a; d_wdata = d;
        tick();
        idle_bus();
    endtask

    task automatic rd(input string name, input logic [31:0] off, input logic [31:0] exp);
        strobe = 1'b1; mem_rw = 1'b0; d_addr = BASE + off; d_wdata = '0;
        #1;
        chk(name, d_rdata, exp);
        tick();
        idle_bus();
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq = m;
        tick();
        irq = '0;
    endtask

    task automatic chk_trap(input string name, input logic exp);
        chk(name, {31'd0, trap}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b1; irq = '0; idle_bus();
        repeat (3) tick();
        reset = 1'b0;
        chk_trap("reset_trap", 1'b0);
        rd("reset_enable", 0, 32'h0);
        rd("reset_pending", 1, 32'h0);
        rd("reset_cause", 2, 32'h0);

        // Single line, basic handshake
        wr(BASE, 32'h08);
        pulse(8'h08);
        chk_trap("s1_trap_latency1", 1'b0);
        tick();
        chk_trap("s1_trap_latency2", 1'b1);
        rd("s1_cause", 2, 32'h3);
        wr(TADDR, 32'h1234);
        chk_trap("s1_ack_trap", 1'b0);
        rd("s1_cause_insvc", 2, 32'h8000_0003);
        rd("s1_pending_clr", 1, 32'h0);
        wr(BASE + 3, 32'hFFFF_FFFF);
        rd("s1_cause_eoi", 2, 32'h3);

        // Priority and re-trap after EOI
        wr(BASE, 32'hFF);
        pulse(8'h24);
        tick();
        chk_trap("s2_trap", 1'b1);
        rd("s2_cause2", 2, 32'h2);
        wr(TADDR, 32'h0);
        wr(BASE + 3, 32'h0);
        chk_trap("s2_trap_after_eoi", 1'b0);
        tick();
        chk_trap("s2_retrap", 1'b1);
        rd("s2_cause5", 2, 32'h5);
        wr(TADDR, 32'h0);
        wr(BASE + 3, 32'h0);

        // Masked line, then enable it; the enabling write itself uses the old mask
        wr(BASE, 32'h0);
        pulse(8'h02);
        tick();
        chk_trap("s3_masked", 1'b0);
        rd("s3_pending", 1, 32'h02);
        wr(BASE, 32'h02);
        chk_trap("s3_old_mask", 1'b0);
        tick();
        chk_trap("s3_enabled", 1'b1);
        rd("s3_cause", 2, 32'h1);
        wr(TADDR, 32'h0);

        // No nesting while in service
        wr(BASE, 32'h03);
        pulse(8'h01);
        tick();
        chk_trap("s4_no_nest", 1'b0);
        rd("s4_pending", 1, 32'h01);
        wr(BASE + 3, 32'h0);
        chk_trap("s4_eoi_edge", 1'b0);
        tick();
        chk_trap("s4_after_eoi", 1'b1);
        rd("s4_cause", 2, 32'h0);
        wr(TADDR, 32'h0);
        wr(BASE + 3, 32'h0);

        // Edge beats W1C in the same cycle
        wr(BASE, 32'h0);
        pulse(8'h10);
        tick();
        rd("s5_pending", 1, 32'h10);
        irq = 8'h10;
        wr(BASE + 1, 32'h10);
        irq = '0;
        rd("s5_edge_wins", 1, 32'h10);
        wr(BASE + 1, 32'h10);
        rd("s5_w1c", 1, 32'h0);

        // Reset while in REQ
        wr(BASE, 32'hFF);
        pulse(8'h40);
        tick();
        chk_trap("s6_req", 1'b1);
        reset = 1'b1;
        tick();
        chk_trap("s6_reset_trap", 1'b0);
        reset = 1'b0;
        rd("s6_pending", 1, 32'h0);
        rd("s6_enable", 0, 32'h0);
        rd("s6_cause", 2, 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int r;
            if ($urandom_range(7) == 0) irq = irq ^ N'(1 << $urandom_range(N - 1));
            reset = ($urandom_range(299) == 0);
            r = int'($urandom_range(15));
            case (r)
                4: begin strobe = 1; mem_rw = 1; d_addr = BASE;     d_wdata = $urandom; end
                5: begin strobe = 1; mem_rw = 1; d_addr = BASE + 1; d_wdata = $urandom; end
                6: begin strobe = 1; mem_rw = 1; d_addr = BASE + 3; d_wdata = $urandom; end
                7, 8, 9: begin strobe = 1; mem_rw = 1; d_addr = TADDR; d_wdata = $urandom; end
                10, 11, 12: begin
                    strobe = 1; mem_rw = 0; d_addr = BASE + $urandom_range(3); d_wdata = '0;
                end
                13: begin
                    strobe = 1; mem_rw = 1'($urandom_range(1)); d_wdata = $urandom;
                    case ($urandom_range(3))
                        0: d_addr = BASE - 1;
                        1: d_addr = BASE + 4;
                        2: d_addr = TADDR;
                        default: d_addr = $urandom;
                    endcase
                    if (d_addr == TADDR) mem_rw = 1'b0;
                end
                default: idle_bus();
            endcase
            tick();
        end
        idle_bus();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
